// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared FSM encodings and sizing helpers for the cache controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cache_ctrl_pkg;

  // Controller FSM encodings; kept as plain constants so legacy tooling can decode them.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MEM_READ  = 2'd1;
  localparam logic [1:0] ST_MEM_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  typedef logic [1:0] state_t;

  // Tag width left over once the line index has been taken from the word address.
  function automatic int tag_bits(input int depth, input int index_bits);
    return depth - index_bits;
  endfunction

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// sat_counter: statistic counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; clr wins over inc in the same cycle.
// Ports: clk, reset (async active-low), inc, clr -> count[CNT_WIDTH].
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 at_max;

  assign at_max = (count_q == {CNT_WIDTH{1'b1}});

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, write-allocate cache in front of a single Ram.
// Latency: read hit 1 cycle, write 2 cycles, read miss 1 cycle after Ram read data is sampled.
// Backpressure: req_ready only in IDLE without flush; one request outstanding at a time.
// Ports: CPU side req_*/resp_*, flush, clear_stats, hit_count/miss_count;
//        Ram side mem_adress/mem_data_in/mem_write_enable/mem_read_enable out,
//        mem_data_out/mem_valid_out in. clk rising edge, reset async active-low.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  // CPU request / response
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [DEPTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_hit,
  // maintenance and statistics
  input  logic                 flush,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  // Ram master port
  output logic [DEPTH-1:0]     mem_adress,
  output logic [WIDTH-1:0]     mem_data_in,
  output logic                 mem_write_enable,
  output logic                 mem_read_enable,
  input  logic [WIDTH-1:0]     mem_data_out,
  input  logic                 mem_valid_out
);

  localparam int TAG_W = tag_bits(DEPTH, INDEX_BITS);
  localparam int LINES = 1 << INDEX_BITS;

  // FSM and latched request
  state_t             state_q, state_d;
  logic [DEPTH-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;

  // Registered outputs
  logic               mem_re_q;
  logic               mem_we_q;
  logic               resp_valid_q;
  logic               resp_hit_q;
  logic [WIDTH-1:0]   resp_rdata_q;

  // Line array: one word per line
  logic [WIDTH-1:0]   line_data_q  [LINES];
  logic [TAG_W-1:0]   line_tag_q   [LINES];
  logic [LINES-1:0]   line_valid_q;

  // Request decode
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic                  lookup_hit;
  logic                  accept;
  logic                  flush_now;
  logic                  fill;

  assign req_idx = req_addr[INDEX_BITS-1:0];
  assign req_tag = req_addr[DEPTH-1:INDEX_BITS];
  assign lat_idx = addr_q[INDEX_BITS-1:0];
  assign lat_tag = addr_q[DEPTH-1:INDEX_BITS];

  assign lookup_hit = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);

  // Only combinational output: the requester must see acceptance in the same cycle.
  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  // Flush is honoured in IDLE only; while busy the requester keeps holding it.
  assign flush_now = (state_q == ST_IDLE) && flush;
  // Read data returned by the Ram while we are waiting for it.
  assign fill      = (state_q == ST_MEM_READ) && mem_valid_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_write) begin
            state_d = ST_MEM_WRITE;
          end else if (lookup_hit) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_MEM_READ;
          end
        end
      end
      ST_MEM_READ: begin
        if (mem_valid_out) begin
          state_d = ST_RESP;
        end
      end
      ST_MEM_WRITE: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to; the enables are mutually exclusive by
  // construction because the states are.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_re_q     <= (state_d == ST_MEM_READ);
      mem_we_q     <= (state_d == ST_MEM_WRITE);
      resp_valid_q <= (state_d == ST_RESP);

      if (accept) begin
        addr_q     <= req_addr;
        resp_hit_q <= lookup_hit;
        if (req_write) begin
          wdata_q <= req_wdata;
        end else if (lookup_hit) begin
          resp_rdata_q <= line_data_q[req_idx];
        end
      end

      if (fill) begin
        resp_rdata_q <= mem_data_out;
      end

      // Writes report zero data; loaded on the way into RESP so the previous
      // read data stays visible until this response.
      if (state_q == ST_MEM_WRITE) begin
        resp_rdata_q <= '0;
      end
    end
  end

  // Line array. Flush and accept are exclusive (req_ready is low during flush),
  // and a fill can only happen outside IDLE, so the branches never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_data_q[i] <= '0;
        line_tag_q[i]  <= '0;
      end
    end else if (flush_now) begin
      line_valid_q <= '0;
    end else if (accept && req_write) begin
      // Write-allocate: the line takes the new word regardless of its old tag.
      line_data_q[req_idx]  <= req_wdata;
      line_tag_q[req_idx]   <= req_tag;
      line_valid_q[req_idx] <= 1'b1;
    end else if (fill) begin
      line_data_q[lat_idx]  <= mem_data_out;
      line_tag_q[lat_idx]   <= lat_tag;
      line_valid_q[lat_idx] <= 1'b1;
    end
  end

  // Both reads and writes are classified at the accept edge.
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept && lookup_hit),
    .clr   (clear_stats),
    .count (hit_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept && !lookup_hit),
    .clr   (clear_stats),
    .count (miss_count)
  );

  assign mem_adress       = addr_q;
  assign mem_data_in      = wdata_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_rdata       = resp_rdata_q;

endmodule
